// File: rtl/pipe_pkg.sv
// Shared types and constants for the generic pipeline stage register.
// Optional skid slot is enabled with PIPE_STAGE_SKID_EN.
package pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CTRL_W_DEF = 16;
  localparam int OCC_W      = 2;

  typedef enum logic [1:0] {
    PIPE_EMPTY = 2'd0,
    PIPE_FULL  = 2'd1,
    PIPE_SKID  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of a pipeline stage: valid bit plus data/ctrl payload.
// Clearing always zeroes ctrl; data is zeroed only when clear_data is set.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic              load,
  input  logic              clear_ctrl,
  input  logic              clear_data,
  input  logic [DATA_W-1:0] load_data,
  input  logic [CTRL_W-1:0] load_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  always_ff @(posedge clock) begin
    if (!nreset) begin
      valid <= 1'b0;
      data  <= '0;
      ctrl  <= '0;
    end else if (clear_ctrl) begin
      valid <= 1'b0;
      ctrl  <= '0;
      if (clear_data)
        data <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      ctrl  <= load_ctrl;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with hold and flush.
// Define PIPE_STAGE_SKID_EN to add a skid slot that registers in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W            = DATA_W_DEF,
  parameter int CTRL_W            = CTRL_W_DEF,
  parameter bit DATA_CLR_ON_FLUSH = 1'b1
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic              hold,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [OCC_W-1:0]  occupancy
);

  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic [CTRL_W-1:0] m_ctrl;
  logic              m_load;
  logic              m_clr;
  logic [DATA_W-1:0] m_ld_data;
  logic [CTRL_W-1:0] m_ld_ctrl;
  logic              s_valid;
  logic              advance;
  logic              in_take;
  logic              out_xfer;
  pipe_state_e       state;

  assign advance  = !flush && !hold;
  assign in_take  = in_valid && in_ready && !flush;
  assign out_xfer = m_valid && out_ready && advance;

  always_comb begin
    state = PIPE_EMPTY;
    if (s_valid)
      state = PIPE_SKID;
    else if (m_valid)
      state = PIPE_FULL;
  end

  pipe_slot #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_main (
    .clock      (clock),
    .nreset     (nreset),
    .load       (m_load),
    .clear_ctrl (m_clr),
    .clear_data (DATA_CLR_ON_FLUSH),
    .load_data  (m_ld_data),
    .load_ctrl  (m_ld_ctrl),
    .valid      (m_valid),
    .data       (m_data),
    .ctrl       (m_ctrl)
  );

`ifdef PIPE_STAGE_SKID_EN
  logic              s_load;
  logic              s_clr;
  logic [DATA_W-1:0] s_data;
  logic [CTRL_W-1:0] s_ctrl;

  // Ready depends only on registered skid state, never on out_ready.
  assign in_ready = nreset && (flush || (!hold && !s_valid));

  always_comb begin
    m_load    = 1'b0;
    m_clr     = 1'b0;
    s_load    = 1'b0;
    s_clr     = 1'b0;
    m_ld_data = in_data;
    m_ld_ctrl = in_ctrl;
    if (flush) begin
      m_clr = 1'b1;
      s_clr = 1'b1;
    end else begin
      unique case (state)
        PIPE_EMPTY: m_load = in_take;
        PIPE_FULL: begin
          if (in_take && !out_xfer)
            s_load = 1'b1;
          else if (in_take)
            m_load = 1'b1;
          else if (out_xfer)
            m_clr = 1'b1;
        end
        PIPE_SKID: begin
          if (out_xfer) begin
            m_load    = 1'b1;
            m_ld_data = s_data;
            m_ld_ctrl = s_ctrl;
            s_clr     = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  pipe_slot #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_skid (
    .clock      (clock),
    .nreset     (nreset),
    .load       (s_load),
    .clear_ctrl (s_clr),
    .clear_data (DATA_CLR_ON_FLUSH),
    .load_data  (in_data),
    .load_ctrl  (in_ctrl),
    .valid      (s_valid),
    .data       (s_data),
    .ctrl       (s_ctrl)
  );

  assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};
`else
  assign s_valid  = 1'b0;
  assign in_ready = nreset
                 && (flush || (!hold && (!m_valid || out_ready)));

  always_comb begin
    m_load    = 1'b0;
    m_clr     = flush;
    m_ld_data = in_data;
    m_ld_ctrl = in_ctrl;
    if (!flush) begin
      unique case (state)
        PIPE_EMPTY: m_load = in_take;
        PIPE_FULL: begin
          if (in_take)
            m_load = 1'b1;
          else if (out_xfer)
            m_clr = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign occupancy = {1'b0, m_valid};
`endif

  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign out_ctrl  = m_ctrl;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg.
// Skid-specific expectations follow PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;

  logic        clock = 1'b0;
  logic        nreset;
  logic        hold;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [15:0] in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [15:0] out_ctrl;
  logic [1:0]  occupancy;

  int total = 0;
  int bad   = 0;

`ifdef PIPE_STAGE_SKID_EN
  localparam logic [1:0] OCC_MAX = 2'd2;
`else
  localparam logic [1:0] OCC_MAX = 2'd1;
`endif

  pipe_stage_reg #(
    .DATA_W            (32),
    .CTRL_W            (16),
    .DATA_CLR_ON_FLUSH (1'b1)
  ) dut (
    .clock     (clock),
    .nreset    (nreset),
    .hold      (hold),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    nreset    = 1'b0;
    hold      = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_ctrl   = '0;
    out_ready = 1'b1;

    tick();
    tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ctrl", out_ctrl, 0);
    check("rst_occ", occupancy, 0);

    nreset = 1'b1;
    settle();
    check("rel_in_ready", in_ready, 1);

    in_valid = 1'b1;
    in_ctrl  = 16'h00A5;
    in_data  = 32'hDEADBEEF;
    tick();
    in_valid = 1'b0;
    check("t1_valid", out_valid, 1);
    check("t1_ctrl", out_ctrl, 16'h00A5);
    check("t1_data", out_data, 32'hDEADBEEF);
    check("t1_occ", occupancy, 1);
    tick();
    check("drain_valid", out_valid, 0);
    check("drain_ctrl", out_ctrl, 0);
    check("drain_data", out_data, 0);

    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = i;
      in_ctrl  = 16'(i);
      settle();
      check("strm_in_ready", in_ready, 1);
      tick();
      check("strm_valid", out_valid, 1);
      check("strm_data", out_data, i);
      check("strm_ctrl", out_ctrl, i);
    end
    in_valid = 1'b0;
    tick();
    check("strm_end_valid", out_valid, 0);

    in_valid = 1'b1;
    in_data  = 32'd5;
    in_ctrl  = 16'h0005;
    tick();
    hold    = 1'b1;
    in_data = 32'd6;
    in_ctrl = 16'h0006;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("hold_in_ready", in_ready, 0);
      tick();
      check("hold_data", out_data, 5);
      check("hold_valid", out_valid, 1);
      check("hold_occ", occupancy, 1);
    end
    hold = 1'b0;
    settle();
    check("unhold_in_ready", in_ready, 1);
    check("unhold_data5", out_data, 5);
    tick();
    in_valid = 1'b0;
    check("unhold_data6", out_data, 6);
    check("unhold_ctrl6", out_ctrl, 6);

    out_ready = 1'b0;
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'd9;
    in_ctrl   = 16'h0009;
    settle();
    check("flush_in_ready", in_ready, 1);
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    check("flush_valid", out_valid, 0);
    check("flush_ctrl", out_ctrl, 0);
    check("flush_data", out_data, 0);
    check("flush_occ", occupancy, 0);
    out_ready = 1'b1;
    tick();
    check("flush_no9", out_valid, 0);

    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'd3;
    in_ctrl   = 16'h0003;
    tick();
    in_valid = 1'b0;
    hold     = 1'b1;
    flush    = 1'b1;
    tick();
    hold  = 1'b0;
    flush = 1'b0;
    check("hflush_valid", out_valid, 0);
    check("hflush_occ", occupancy, 0);

    in_valid = 1'b1;
    in_data  = 32'd7;
    in_ctrl  = 16'h0007;
    tick();
    in_data = 32'd8;
    in_ctrl = 16'h0008;
    settle();
`ifdef PIPE_STAGE_SKID_EN
    check("bp_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("bp_occ", occupancy, 2);
    check("bp_in_ready_full", in_ready, 0);
    check("bp_head", out_data, 7);
    out_ready = 1'b1;
    settle();
    check("bp_first", out_data, 7);
    tick();
    check("bp_second", out_data, 8);
    check("bp_ctrl2", out_ctrl, 8);
    check("bp_occ1", occupancy, 1);
    tick();
`else
    check("bp_in_ready", in_ready, 0);
    tick();
    check("bp_occ", occupancy, 1);
    check("bp_head", out_data, 7);
    out_ready = 1'b1;
    settle();
    check("bp_in_ready_go", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("bp_second", out_data, 8);
    check("bp_ctrl2", out_ctrl, 8);
    tick();
`endif
    check("bp_empty_occ", occupancy, 0);
    check("bp_empty_valid", out_valid, 0);

    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h11;
    in_ctrl   = 16'h0011;
    tick();
    in_data = 32'h22;
    in_ctrl = 16'h0022;
    tick();
    in_valid = 1'b0;
    check("pre_rst_occ", occupancy, OCC_MAX);
    nreset    = 1'b0;
    out_ready = 1'b1;
    tick();
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ctrl", out_ctrl, 0);
    check("mid_rst_occ", occupancy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    nreset = 1'b1;
    settle();
    check("post_rst_in_ready", in_ready, 1);
    tick();
    check("post_rst_valid", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
